fw_interface_wb_slave: RTL and testbench

//  Firmware-facing Wishbone slave that generates the fw-interface signals consumed by the testbench checker.

---
 rtl/fw_interface_pkg.sv | 47 ++++
 rtl/fw_interface_char_fifo.sv | 54 +++++
 rtl/fw_interface_wb_slave.sv | 181 ++++++++++++++++++
 tb/tb_fw_interface_wb_slave.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_interface_pkg.sv
// Shared definitions for the firmware-interface Wishbone slave: register map,
// command bit positions, FSM encoding and string-memory geometry.
package fw_interface_pkg;

  localparam logic [2:0] OFF_REPORT   = 3'd0;
  localparam logic [2:0] OFF_WARNING  = 3'd1;
  localparam logic [2:0] OFF_ERROR    = 3'd2;
  localparam logic [2:0] OFF_EXPECTED = 3'd3;
  localparam logic [2:0] OFF_MEASURED = 3'd4;
  localparam logic [2:0] OFF_CHAR     = 3'd5;
  localparam logic [2:0] OFF_CMD      = 3'd6;
  localparam logic [2:0] OFF_STATUS   = 3'd7;

  localparam int CMD_REPORT  = 0;
  localparam int CMD_WARNING = 1;
  localparam int CMD_ERROR   = 2;
  localparam int CMD_COMPARE = 3;

  localparam int         STR_MAX   = 64;
  // Last slot of the receiver's string memory is kept for the terminator.
  localparam logic [5:0] NUL_INDEX = 6'(STR_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_TERM,
    ST_PULSE,
    ST_GAP
  } fw_state_e;

  // One-hot of the lowest set bit, so simultaneous command bits resolve to one.
  function automatic logic [3:0] cmd_select(input logic [3:0] cmd);
    return cmd & (~cmd + 4'd1);
  endfunction

  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fw_interface_char_fifo.sv
// Synchronous 8-bit character FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module fw_interface_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/fw_interface_wb_slave.sv
// Wishbone slave that streams firmware messages into the checker's string
// memory and pulses new_*; FW_INTERFACE_READBACK_EN enables register readback.
module fw_interface_wb_slave
  import fw_interface_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int PULSE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        new_report,
  output logic        new_warning,
  output logic        new_error,
  output logic        new_compare,
  output logic [31:0] report_reg,
  output logic [31:0] warning_reg,
  output logic [31:0] error_reg,
  output logic [31:0] expected_reg,
  output logic [31:0] measured_reg,
  output logic [5:0]  index,
  output logic [7:0]  data,
  output logic        write_mem
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a request is cyc&stb with ack low; it is accepted (and acked on
  // the next edge) unless it stalls, and all register side effects happen on
  // that same acking edge.
  fw_state_e   state, state_next;
  logic [2:0]  off;
  logic        bus_req, char_stall, cmd_stall, accept, wr_acc;
  logic        busy;
  logic [3:0]  pending;
  logic [7:0]  cnt;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [LW-1:0] fifo_level;
  logic        unused_bits;

  assign off         = wb_adr_i[4:2];
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  assign busy       = (state != ST_IDLE) | ~fifo_empty;
  assign bus_req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign char_stall = wb_we_i & (off == OFF_CHAR) & (wb_dat_i[7:0] != 8'h00) & fifo_full;
  // Pending is included so a second command cannot slip in before TERM starts.
  assign cmd_stall  = wb_we_i & (off == OFF_CMD) & (wb_dat_i[3:0] != 4'h0) &
                      (busy | (pending != 4'h0));
  assign accept     = bus_req & ~char_stall & ~cmd_stall;
  assign wr_acc     = accept & wb_we_i;
  assign fifo_push  = wr_acc & (off == OFF_CHAR) & (wb_dat_i[7:0] != 8'h00);

  fw_interface_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wb_dat_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wb_ack_o     <= 1'b0;
      report_reg   <= '0;
      warning_reg  <= '0;
      error_reg    <= '0;
      expected_reg <= '0;
      measured_reg <= '0;
    end else begin
      wb_ack_o <= accept;
      if (wr_acc) begin
        case (off)
          OFF_REPORT:   report_reg   <= apply_sel(report_reg,   wb_dat_i, wb_sel_i);
          OFF_WARNING:  warning_reg  <= apply_sel(warning_reg,  wb_dat_i, wb_sel_i);
          OFF_ERROR:    error_reg    <= apply_sel(error_reg,    wb_dat_i, wb_sel_i);
          OFF_EXPECTED: expected_reg <= apply_sel(expected_reg, wb_dat_i, wb_sel_i);
          OFF_MEASURED: measured_reg <= apply_sel(measured_reg, wb_dat_i, wb_sel_i);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    write_mem  = 1'b0;
    data       = 8'h00;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty)            state_next = ST_STREAM;
        else if (pending != 4'h0)   state_next = ST_TERM;
      end
      ST_STREAM: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
        end else begin
          fifo_pop = 1'b1;
          if (index != NUL_INDEX) begin
            write_mem = 1'b1;
            data      = fifo_dout;
          end
        end
      end
      ST_TERM: begin
        write_mem  = 1'b1;
        state_next = ST_PULSE;
      end
      ST_PULSE: if (cnt == 8'(PULSE_CYCLES - 1)) state_next = ST_GAP;
      ST_GAP:   if (cnt == 8'd1)                 state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      index   <= '0;
      pending <= '0;
    end else begin
      state <= state_next;
      cnt   <= ((state == ST_PULSE || state == ST_GAP) && state_next == state) ?
               cnt + 8'd1 : 8'd0;
      if (state == ST_STREAM && write_mem) index <= index + 6'd1;
      else if (state == ST_GAP)            index <= '0;
      if (state == ST_GAP && state_next == ST_IDLE)
        pending <= '0;
      else if (wr_acc && off == OFF_CMD && wb_dat_i[3:0] != 4'h0)
        pending <= cmd_select(wb_dat_i[3:0]);
    end
  end

  assign new_report  = (state == ST_PULSE) & pending[CMD_REPORT];
  assign new_warning = (state == ST_PULSE) & pending[CMD_WARNING];
  assign new_error   = (state == ST_PULSE) & pending[CMD_ERROR];
  assign new_compare = (state == ST_PULSE) & pending[CMD_COMPARE];

`ifdef FW_INTERFACE_READBACK_EN
  logic [31:0] rd_mux;
  logic        unused_rb;
  assign unused_rb = unused_bits;

  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_REPORT:   rd_mux = report_reg;
      OFF_WARNING:  rd_mux = warning_reg;
      OFF_ERROR:    rd_mux = error_reg;
      OFF_EXPECTED: rd_mux = expected_reg;
      OFF_MEASURED: rd_mux = measured_reg;
      OFF_STATUS:   rd_mux = {16'h0, 8'(fifo_level), 6'h0, fifo_full, busy};
      default:      rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i)              wb_dat_o <= '0;
    else if (accept && !wb_we_i) wb_dat_o <= rd_mux;
    else                        wb_dat_o <= '0;
  end
`else
  logic unused_rb;
  assign unused_rb = ^{unused_bits, fifo_level};
  assign wb_dat_o  = '0;
`endif

endmodule

// File: tb/tb_fw_interface_wb_slave.sv
// Directed bench for fw_interface_wb_slave: bus writes, string-memory
// scoreboard, and new_* pulse monitor.
module tb_fw_interface_wb_slave;

  localparam logic [2:0] R_REPORT = 3'd0, R_WARNING = 3'd1, R_ERROR = 3'd2;
  localparam logic [2:0] R_EXPECTED = 3'd3, R_MEASURED = 3'd4, R_CHAR = 3'd5;
  localparam logic [2:0] R_CMD = 3'd6, R_STATUS = 3'd7;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;
  logic        new_report, new_warning, new_error, new_compare;
  logic [31:0] report_reg, warning_reg, error_reg, expected_reg, measured_reg;
  logic [5:0]  index;
  logic [7:0]  data;
  logic        write_mem;

  fw_interface_wb_slave dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
    .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack),
    .new_report(new_report), .new_warning(new_warning), .new_error(new_error),
    .new_compare(new_compare), .report_reg(report_reg), .warning_reg(warning_reg),
    .error_reg(error_reg), .expected_reg(expected_reg), .measured_reg(measured_reg),
    .index(index), .data(data), .write_mem(write_mem)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef FW_INTERFACE_READBACK_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // scoreboard and pulse monitor
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic [3:0]  pulse_vec_q[$];
  int          pulse_len_q[$];
  int          pulse_gap_q[$];
  logic [3:0]  prev_vec = 4'h0, cur_vec = 4'h0;
  int          cur_len = 0, cur_gap = 0, zero_run = 1000, overlap_err = 0;
  logic [31:0] snap_exp = 0, snap_meas = 0;

  initial begin
    logic [3:0] vec;
    forever begin
      @(negedge clk);
      if (write_mem) obs_q.push_back({index, data});
      vec = {new_compare, new_error, new_warning, new_report};
      if (!$onehot0(vec)) overlap_err++;
      if (vec != 4'h0) begin
        if (prev_vec == 4'h0) begin
          cur_vec = vec; cur_len = 1; cur_gap = zero_run;
          snap_exp = expected_reg; snap_meas = measured_reg;
        end else begin
          if (vec != prev_vec) overlap_err++;
          cur_len++;
        end
        zero_run = 0;
      end else begin
        if (prev_vec != 4'h0) begin
          pulse_vec_q.push_back(cur_vec);
          pulse_len_q.push_back(cur_len);
          pulse_gap_q.push_back(cur_gap);
        end
        zero_run++;
      end
      prev_vec = vec;
    end
  end

  // driver tasks
  task automatic wb_cycle(input logic [2:0] off, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int waited);
    wb_adr = {27'd0, off, 2'b00}; wb_dat_w = d; wb_sel = s;
    wb_we = w; wb_cyc = 1'b1; wb_stb = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1; waited++;
    end while (!wb_ack && waited < 3000);
    if (!wb_ack) check_eq("ack_timeout", {31'd0, wb_ack}, 32'd1);
    rd = wb_dat_r;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] off, input logic [31:0] d);
    logic [31:0] rd; int w;
    wb_cycle(off, 1'b1, d, 4'hF, rd, w);
  endtask

  task automatic wb_read(input logic [2:0] off, output logic [31:0] rd);
    int w;
    wb_cycle(off, 1'b0, 32'h0, 4'hF, rd, w);
  endtask

  task automatic push_char(input logic [7:0] c);
    wb_write(R_CHAR, {24'h0, c});
  endtask

  task automatic settle();
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic drain_sb(input string tag);
    logic [13:0] o, e;
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      check_eq({tag, "_byte"}, {18'd0, o}, {18'd0, e});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic expect_pulse(input string tag, input logic [3:0] vec);
    check_eq({tag, "_present"}, {31'd0, pulse_vec_q.size() != 0}, 32'd1);
    if (pulse_vec_q.size() != 0) begin
      check_eq({tag, "_which"}, {28'd0, pulse_vec_q.pop_front()}, {28'd0, vec});
      check_eq({tag, "_len"}, pulse_len_q.pop_front(), 32'd4);
      check_eq({tag, "_gap"}, {31'd0, pulse_gap_q.pop_front() >= 2}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  ch;
    int          waited;
    int          n;
    rst_n = 1'b0; wb_adr = 0; wb_dat_w = 0; wb_sel = 0; wb_we = 0; wb_cyc = 0; wb_stb = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {31'd0, wb_ack}, 0);
    check_eq("rst_wm", {31'd0, write_mem}, 0);
    check_eq("rst_index", {26'd0, index}, 0);
    check_eq("rst_new", {28'd0, new_compare, new_error, new_warning, new_report}, 0);
    check_eq("rst_dat", wb_dat_r, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // value registers with byte enables
    wb_cycle(R_REPORT, 1'b1, 32'hAABBCCDD, 4'b0101, rd, waited);
    check_eq("report_sel", report_reg, 32'h00BB00DD);
    check_eq("ack_latency", waited, 1);
    wb_write(R_WARNING, 32'h11223344);
    wb_write(R_ERROR, 32'hDEADBEEF);
    check_eq("warning_reg", warning_reg, 32'h11223344);
    check_eq("error_reg", error_reg, 32'hDEADBEEF);
    wb_read(R_ERROR, rd);   check_eq("rd_error", rd, rb(32'hDEADBEEF));
    wb_read(R_REPORT, rd);  check_eq("rd_report", rd, rb(32'h00BB00DD));
    wb_read(R_CHAR, rd);    check_eq("rd_char", rd, 0);
    wb_read(R_STATUS, rd);  check_eq("rd_status_idle", rd, 0);

    // "Hi" with a dropped NUL char and a no-op CMD 0
    push_char("H"); push_char(8'h00); push_char("i");
    wb_write(R_CMD, 32'h0);
    wb_write(R_CMD, 32'h1);
    exp_q.push_back({6'd0, 8'h48}); exp_q.push_back({6'd1, 8'h69}); exp_q.push_back({6'd2, 8'h00});
    settle();
    drain_sb("hi");
    expect_pulse("hi_pulse", 4'b0001);
    check_eq("hi_index_back", {26'd0, index}, 0);

    // compare, values visible before the pulse; then lowest-bit priority
    wb_write(R_EXPECTED, 32'h1234);
    wb_write(R_MEASURED, 32'h1234);
    push_char("C");
    wb_write(R_CMD, 32'h8);
    exp_q.push_back({6'd0, 8'h43}); exp_q.push_back({6'd1, 8'h00});
    settle();
    drain_sb("cmp");
    expect_pulse("cmp_pulse", 4'b1000);
    check_eq("cmp_snap_exp", snap_exp, 32'h1234);
    check_eq("cmp_snap_meas", snap_meas, 32'h1234);
    wb_write(R_CMD, 32'hE);
    exp_q.push_back({6'd0, 8'h00});
    settle();
    drain_sb("prio");
    expect_pulse("prio_pulse", 4'b0010);

    // 17 chars back-to-back, all in order
    for (int i = 0; i < 17; i++) begin
      ch = 8'(8'h61 + i);
      push_char(ch);
      exp_q.push_back({6'(i), ch});
    end
    wb_write(R_CMD, 32'h1);
    exp_q.push_back({6'd17, 8'h00});
    settle();
    drain_sb("seq17");
    expect_pulse("seq17_pulse", 4'b0001);

    // 70 chars: saturate at slot 63 for the terminator
    for (int i = 0; i < 70; i++) begin
      ch = 8'(8'h41 + (i % 26));
      push_char(ch);
      if (i < 63) exp_q.push_back({6'(i), ch});
    end
    wb_write(R_CMD, 32'h1);
    exp_q.push_back({6'd63, 8'h00});
    settle();
    drain_sb("long");
    expect_pulse("long_pulse", 4'b0001);
    check_eq("long_index_back", {26'd0, index}, 0);

    // command while busy stalls until idle
    wb_write(R_CMD, 32'h1);
    wb_cycle(R_CMD, 1'b1, 32'h4, 4'hF, rd, waited);
    check_eq("busy_cmd_stalled", {31'd0, waited > 4}, 1);
    exp_q.push_back({6'd0, 8'h00}); exp_q.push_back({6'd0, 8'h00});
    settle();
    drain_sb("busy");
    expect_pulse("busy_first", 4'b0001);
    expect_pulse("busy_second", 4'b0100);
    check_eq("overlap", overlap_err, 0);

    // reset in the middle of a pulse
    push_char("x"); push_char("y");
    wb_write(R_CMD, 32'h2);
    n = 0;
    while (!new_warning && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("rstp_pulse_seen", {31'd0, new_warning}, 1);
    check_eq("rstp_index_pre", {26'd0, index}, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rstp_new", {28'd0, new_compare, new_error, new_warning, new_report}, 0);
    check_eq("rstp_wm", {31'd0, write_mem}, 0);
    check_eq("rstp_index", {26'd0, index}, 0);
    check_eq("rstp_regs", expected_reg | report_reg, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_read(R_STATUS, rd);
    check_eq("rstp_status", rd, 0);
    settle();
    check_eq("rstp_no_write", obs_q.size(), 3);
    obs_q.delete(); pulse_vec_q.delete(); pulse_len_q.delete(); pulse_gap_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
